button_capture: RTL and testbench
=================================

BUTTON_CAPTURE -- requirements
Module: button_capture

Interface
REQ-001 Parameter N_BTN, default 4: number of game buttons/LED channels; legal range 2..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz): stable-level cycles needed to accept a press or a release; legal minimum 1.
REQ-003 Parameter IDX_W, default $clog2(N_BTN): width of press_idx.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 btn_in  input  N_BTN  raw asynchronous button levels, active-high; bit i is channel i.
REQ-007 btn_clr  input  1  raw asynchronous clear button, active-high.
REQ-008 led  output  N_BTN  one-hot last accepted press, or all-zero after reset/clear.
REQ-009 press_valid  output  1  single-cycle pulse, one per accepted press.
REQ-010 press_idx  output  IDX_W  index of last accepted press; valid whenever press_valid=1, held otherwise.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Each btn_in bit and btn_clr SHALL pass through its own 2-flop synchronizer before any use; "synced" below means the synchronizer output.
REQ-013 The FSM SHALL have exactly four states: IDLE, ARM, HELD, REL.
REQ-014 IDLE: if any synced button is high, capture the lowest high index as cand, clear the counter, go to ARM.
REQ-015 ARM: if synced btn[cand] is low, go to IDLE with no output change; otherwise increment the counter.
REQ-016 ARM: when the counter reaches DEBOUNCE_CYCLES-1 with btn[cand] still high, on the next edge set led to one-hot(cand), set press_idx to cand, pulse press_valid for one cycle, and go to HELD.
REQ-017 Latency: if btn_in[i] is stable high from edge k, press_valid SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+2.
REQ-018 Simultaneous presses: only the lowest-index button SHALL be accepted; other buttons pressed during ARM or HELD SHALL never generate a press.
REQ-019 HELD: remain until all synced buttons are low, then clear the counter and go to REL.
REQ-020 REL: if any synced button is high, go to HELD; otherwise increment the counter; at DEBOUNCE_CYCLES-1, go to IDLE.
REQ-021 Consequence of REQ-019/020: a button held indefinitely SHALL produce exactly one press_valid (no auto-repeat).
REQ-022 Consequence of REQ-019/020: a release glitch shorter than DEBOUNCE_CYCLES SHALL NOT produce a second press.
REQ-023 led and press_idx SHALL change only on an accepted press or on a clear, and SHALL hold their value in all other cycles.
REQ-024 Clear: synced btn_clr high in any state SHALL, on the next edge, set led=0, keep press_idx, hold press_valid=0, and force HELD.
REQ-025 Clear has priority over a press completing in the same cycle; no button press is accepted until after the REL debounce (REQ-020).
REQ-026 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, saturate rather than wrap, and hold in IDLE and HELD.

Reset
REQ-027 rst_n low SHALL immediately and asynchronously force: state=IDLE, counter=0, cand=0, synchronizers=0, led=0, press_idx=0, press_valid=0, busy=0.
REQ-028 Reset deasserted mid-press: a button already high SHALL be treated as a new press needing a full debounce.
REQ-029 Reset asserted during ARM SHALL discard the candidate with no press_valid.

Verification (DEBOUNCE_CYCLES=4, N_BTN=4 unless stated)
REQ-030 Hold btn_in=0100 from edge 10 for 20 cycles -> one press_valid pulse in the cycle after edge 16, press_idx=2, led=0100; no further pulse.
REQ-031 btn_in=0001 for 3 cycles, then 0 -> no press_valid; led stays 0000; FSM returns to IDLE.
REQ-032 btn_in=1010 together -> press_idx=1, led=0010; then 1000 alone after full release and 4-cycle quiet -> press_idx=3, led=1000.
REQ-033 Accepted press on bit 0, then a 2-cycle release glitch, then held again -> exactly one press_valid total.
REQ-034 led=0100, then btn_clr pulsed for 3 cycles -> led=0000 two edges after clr rises; no press_valid; next valid press accepted normally.
REQ-035 rst_n pulled low for 1 cycle during ARM -> all outputs 0 immediately; a button held through reset gives press_valid 7 cycles after the first rising clock edge with rst_n high; repeat with N_BTN=8 on bit 7 -> press_idx=7.

Source files
------------

// File: rtl/button_capture.sv
// Debounced button capture: latches the lowest pressed channel onto a one-hot LED
// bank and emits one press pulse per debounced press; btn_clr blanks the LEDs.
module button_capture #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int IDX_W           = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             btn_clr,
  output logic [N_BTN-1:0] led,
  output logic             press_valid,
  output logic [IDX_W-1:0] press_idx,
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [N_BTN-1:0] ONE = N_BTN'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HELD,
    REL
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IDX_W-1:0] cand;
  logic [N_BTN:0]   meta;
  logic [N_BTN:0]   sync;

  logic [N_BTN-1:0] syncBtn;
  logic             syncClr;
  logic             anyBtn;
  logic             candHigh;
  logic [IDX_W-1:0] lowIdx;
  logic [CW-1:0]    cntInc;

  assign syncBtn  = sync[N_BTN-1:0];
  assign syncClr  = sync[N_BTN];
  assign anyBtn   = |syncBtn;
  assign candHigh = syncBtn[cand];
  assign cntInc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
  assign busy     = (state != IDLE);

  // Scan from the top so the lowest set index wins.
  always_comb begin
    lowIdx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (syncBtn[i]) lowIdx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {btn_clr, btn_in};
      sync <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      led         <= '0;
      press_idx   <= '0;
      press_valid <= 1'b0;
    end else begin
      press_valid <= 1'b0;
      if (syncClr) begin
        // Clear wins over everything, including a press finishing now.
        led   <= '0;
        cnt   <= '0;
        state <= HELD;
      end else begin
        unique case (state)
          IDLE: begin
            if (anyBtn) begin
              cand  <= lowIdx;
              cnt   <= '0;
              state <= ARM;
            end
          end
          ARM: begin
            if (!candHigh) begin
              state <= IDLE;
            end else if (cnt == CNT_LAST) begin
              led         <= ONE << cand;
              press_idx   <= cand;
              press_valid <= 1'b1;
              state       <= HELD;
            end else begin
              cnt <= cntInc;
            end
          end
          HELD: begin
            if (!anyBtn) begin
              cnt   <= '0;
              state <= REL;
            end
          end
          REL: begin
            if (anyBtn) begin
              state <= HELD;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE;
            end else begin
              cnt <= cntInc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_capture.sv
// Directed bench for button_capture: vector table plus latency,
// glitch, clear and reset corner sequences.
module tb_button_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       clr;
  logic [3:0] led;
  logic       pv;
  logic [1:0] idx;
  logic       busy;

  logic [7:0] btn8;
  logic       clr8;
  logic [7:0] led8;
  logic       pv8;
  logic [2:0] idx8;
  logic       busy8;

  int total = 0;
  int passed = 0;
  int pulses = 0;
  int pulses8 = 0;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    int         expPulses;
    logic [1:0] expIdx;
    logic [3:0] expLed;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  button_capture #(
    .N_BTN(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn),
    .btn_clr(clr),
    .led(led),
    .press_valid(pv),
    .press_idx(idx),
    .busy(busy)
  );

  button_capture #(
    .N_BTN(8),
    .DEBOUNCE_CYCLES(4)
  ) dut8 (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn8),
    .btn_clr(clr8),
    .led(led8),
    .press_valid(pv8),
    .press_idx(idx8),
    .busy(busy8)
  );

  always @(negedge clk) begin
    if (pv === 1'b1) pulses++;
    if (pv8 === 1'b1) pulses8++;
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{4'b0001, 3, 0, 2'd0, 4'b0000};
    vecs[1] = '{4'b0100, 20, 1, 2'd2, 4'b0100};
    vecs[2] = '{4'b1010, 10, 1, 2'd1, 4'b0010};
    vecs[3] = '{4'b1000, 10, 1, 2'd3, 4'b1000};
    vecs[4] = '{4'b1111, 12, 1, 2'd0, 4'b0001};
    vecs[5] = '{4'b0010, 2, 0, 2'd0, 4'b0001};
    vecs[6] = '{4'b0110, 40, 1, 2'd1, 4'b0010};
    vecs[7] = '{4'b0100, 4, 0, 2'd1, 4'b0010};

    rst_n = 1'b0;
    btn   = '0;
    clr   = 1'b0;
    btn8  = '0;
    clr8  = 1'b0;
    tick(3);
    check("rst led", 32'(led), 32'h0);
    check("rst valid", 32'(pv), 32'h0);
    check("rst idx", 32'(idx), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst led8", 32'(led8), 32'h0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 8; i++) begin
      pulses = 0;
      btn = vecs[i].btn;
      tick(vecs[i].hold);
      btn = '0;
      tick(10);
      check($sformatf("vec%0d pulses", i), 32'(pulses),
            32'(vecs[i].expPulses));
      check($sformatf("vec%0d idx", i), 32'(idx), 32'(vecs[i].expIdx));
      check($sformatf("vec%0d led", i), 32'(led), 32'(vecs[i].expLed));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
    end

    // Exact press latency: pulse only in the 7th cycle after driving.
    btn = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      check($sformatf("latency c%0d", c), 32'(pv), 32'(c == 7));
    end
    check("latency idx", 32'(idx), 32'h2);
    check("latency led", 32'(led), 32'h4);
    btn = '0;
    tick(10);

    // Short release glitch must not re-trigger.
    pulses = 0;
    btn = 4'b0001;
    tick(10);
    btn = '0;
    tick(2);
    btn = 4'b0001;
    tick(10);
    btn = '0;
    tick(10);
    check("glitch pulses", 32'(pulses), 32'h1);
    check("glitch idx", 32'(idx), 32'h0);
    check("glitch busy", 32'(busy), 32'h0);

    // Clear: led drops two edges after clr is sampled.
    btn = 4'b0100;
    tick(10);
    btn = '0;
    tick(10);
    check("clr pre led", 32'(led), 32'h4);
    pulses = 0;
    clr = 1'b1;
    tick(2);
    check("clr early led", 32'(led), 32'h4);
    tick(1);
    check("clr led", 32'(led), 32'h0);
    check("clr idx", 32'(idx), 32'h2);
    check("clr busy", 32'(busy), 32'h1);
    clr = 1'b0;
    tick(10);
    check("clr pulses", 32'(pulses), 32'h0);
    check("clr idle", 32'(busy), 32'h0);
    btn = 4'b0001;
    tick(10);
    btn = '0;
    tick(10);
    check("post clr pulses", 32'(pulses), 32'h1);
    check("post clr idx", 32'(idx), 32'h0);
    check("post clr led", 32'(led), 32'h1);

    // Reset during ARM, buttons held through reset.
    btn  = 4'b0001;
    btn8 = 8'h80;
    tick(4);
    check("arm busy", 32'(busy), 32'h1);
    check("arm busy8", 32'(busy8), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async led", 32'(led), 32'h0);
    check("async idx", 32'(idx), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async valid", 32'(pv), 32'h0);
    check("async busy8", 32'(busy8), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rearm c%0d", c), 32'(pv), 32'(c == 7));
      check($sformatf("rearm8 c%0d", c), 32'(pv8), 32'(c == 7));
    end
    check("rearm idx", 32'(idx), 32'h0);
    check("rearm led", 32'(led), 32'h1);
    check("rearm idx8", 32'(idx8), 32'h7);
    check("rearm led8", 32'(led8), 32'h80);
    btn  = '0;
    btn8 = '0;
    tick(10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
